// File: rtl/window_gen_3x3_pkg.sv
// Shared definitions for the edge-detection pipeline: default pixel width,
// pixel type and the frame-position state encoding of the window generator.
package pkg_edge;

  localparam int DEFAULT_PIX_W = 8;

  typedef logic [DEFAULT_PIX_W-1:0] pix_t;

  // Frame position of the window generator.
  //   FILL  : first IMG_W+1 pixels of a frame, no window can be centred yet
  //   RUN   : every accepted pixel completes one window
  //   FLUSH : input closed, remaining IMG_W+1 centres emitted one per cycle
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One-row delay line: single address, combinational read of the old entry
// and write of the new entry on the same enabled clock edge, so the value
// read out is the pixel written one row earlier at the same column.
module line_buffer #(
  parameter int DEPTH = 415,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read sees the stored entry before this edge's write lands.
  assign dout = mem[addr];

  // Contents need no reset: every entry read at a border is masked, and
  // every entry read in the interior was written earlier in the same frame.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 zero-padded window generator.
//
// Handshake: a pixel transfers on a rising edge where in_valid && in_ready.
// in_ready is a registered decode of the state (low only in FLUSH) and never
// depends on in_valid. The window side has no back-pressure: win_valid is a
// one-cycle pulse and the window outputs hold their last value otherwise.
//
// Datapath: accepting pixel k at (row, col) reads the two line buffers at
// col, giving the pixels at k-IMG_W and k-2*IMG_W. Together with the new
// pixel these form the newest (right) column of the window; the two older
// columns live in a small shift register. The centre is therefore at
// linear index k-IMG_W-1. Borders are decided purely from the centre
// coordinates by masking, so stale or wrapped data never reaches a tap.
module window_gen_3x3
  import pkg_edge::*;
#(
  parameter int IMG_W = 415,
  parameter int IMG_H = 738,
  parameter int PIX_W = DEFAULT_PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PIX_W-1:0]         in_pix,
  output logic                     in_ready,
  output logic [PIX_W-1:0]         p00,
  output logic [PIX_W-1:0]         p01,
  output logic [PIX_W-1:0]         p02,
  output logic [PIX_W-1:0]         p10,
  output logic [PIX_W-1:0]         p11,
  output logic [PIX_W-1:0]         p12,
  output logic [PIX_W-1:0]         p20,
  output logic [PIX_W-1:0]         p21,
  output logic [PIX_W-1:0]         p22,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     win_last,
  output logic [1:0]               fsm_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  state_t state_q;
  state_t state_d;

  // Input position: column doubles as the line-buffer address.
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  // Position of the next window centre to be emitted.
  logic [CW-1:0] cen_col;
  logic [RW-1:0] cen_row;

  logic accept;       // pixel transfers this edge
  logic step;         // window columns advance this edge
  logic emit;         // a window is produced this edge
  logic fill_done;    // accepting pixel IMG_W
  logic last_accept;  // accepting the final pixel of the frame
  logic last_cen;     // current centre is the bottom-right pixel
  logic frame_end;    // last window of the frame leaves this edge

  logic [PIX_W-1:0] lb1_dout;
  logic [PIX_W-1:0] lb2_dout;

  // Newest window column (rows r-1, r, r+1 relative to the centre).
  logic [PIX_W-1:0] n_top;
  logic [PIX_W-1:0] n_mid;
  logic [PIX_W-1:0] n_bot;

  // Two older window columns: a = left of centre, b = centre column.
  logic [PIX_W-1:0] a_top;
  logic [PIX_W-1:0] a_mid;
  logic [PIX_W-1:0] a_bot;
  logic [PIX_W-1:0] b_top;
  logic [PIX_W-1:0] b_mid;
  logic [PIX_W-1:0] b_bot;

  // Border-masked taps of the window being emitted.
  logic [PIX_W-1:0] m00;
  logic [PIX_W-1:0] m01;
  logic [PIX_W-1:0] m02;
  logic [PIX_W-1:0] m10;
  logic [PIX_W-1:0] m11;
  logic [PIX_W-1:0] m12;
  logic [PIX_W-1:0] m20;
  logic [PIX_W-1:0] m21;
  logic [PIX_W-1:0] m22;

  logic top_z;
  logic bot_z;
  logic left_z;
  logic right_z;

  assign accept      = in_valid && in_ready;
  assign step        = accept || (state_q == FLUSH);
  assign emit        = (accept && (state_q == RUN)) || (state_q == FLUSH);
  assign fill_done   = accept && (in_row == ROW_ONE) && (in_col == '0);
  assign last_accept = accept && (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign last_cen    = (cen_row == ROW_LAST) && (cen_col == COL_LAST);
  assign frame_end   = (state_q == FLUSH) && last_cen;

  assign fsm_state = state_q;

  // Cascaded row delays: lb1 yields row-1, lb2 yields row-2 at this column.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .addr (in_col),
    .din  (in_pix),
    .dout (lb1_dout)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb2 (
    .clk  (clk),
    .en   (accept),
    .addr (in_col),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // During FLUSH there is no new input row; the bottom tap is synthesised
  // as zero (it is masked as the frame's bottom border anyway).
  assign n_top = lb2_dout;
  assign n_mid = lb1_dout;
  assign n_bot = (state_q == FLUSH) ? '0 : in_pix;

  // Next-state decode: fill, run, flush, then back to fill for the next frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fill_done)   state_d = RUN;
      RUN:     if (last_accept) state_d = FLUSH;
      FLUSH:   if (last_cen)    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State register; in_ready is the registered "not flushing" decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != FLUSH);
    end
  end

  // Input and centre position counters; cleared only by reset or frame end.
  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      in_col  <= '0;
      in_row  <= '0;
      cen_col <= '0;
      cen_row <= '0;
    end else begin
      if (step) begin
        in_col <= (in_col == COL_LAST) ? '0 : in_col + CW'(1);
      end
      // The row stops at the last row; FLUSH only needs the column pointer.
      if (accept && (in_col == COL_LAST) && (in_row != ROW_LAST)) begin
        in_row <= in_row + RW'(1);
      end
      if (emit) begin
        if (cen_col == COL_LAST) begin
          cen_col <= '0;
          cen_row <= cen_row + RW'(1);
        end else begin
          cen_col <= cen_col + CW'(1);
        end
      end
    end
  end

  // Zero padding decided from the centre coordinates only.
  always_comb begin
    top_z   = (cen_row == '0);
    bot_z   = (cen_row == ROW_LAST);
    left_z  = (cen_col == '0);
    right_z = (cen_col == COL_LAST);

    m00 = (top_z || left_z)  ? '0 : a_top;
    m01 = top_z              ? '0 : b_top;
    m02 = (top_z || right_z) ? '0 : n_top;
    m10 = left_z             ? '0 : a_mid;
    m11 = b_mid;
    m12 = right_z            ? '0 : n_mid;
    m20 = (bot_z || left_z)  ? '0 : a_bot;
    m21 = bot_z              ? '0 : b_bot;
    m22 = (bot_z || right_z) ? '0 : n_bot;
  end

  // Column shift register and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_top     <= '0;
      a_mid     <= '0;
      a_bot     <= '0;
      b_top     <= '0;
      b_mid     <= '0;
      b_bot     <= '0;
      p00       <= '0;
      p01       <= '0;
      p02       <= '0;
      p10       <= '0;
      p11       <= '0;
      p12       <= '0;
      p20       <= '0;
      p21       <= '0;
      p22       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= emit;
      win_last  <= emit && last_cen;
      if (step) begin
        a_top <= b_top;
        a_mid <= b_mid;
        a_bot <= b_bot;
        b_top <= n_top;
        b_mid <= n_mid;
        b_bot <= n_bot;
      end
      if (emit) begin
        p00     <= m00;
        p01     <= m01;
        p02     <= m02;
        p10     <= m10;
        p11     <= m11;
        p12     <= m12;
        p20     <= m20;
        p21     <= m21;
        p22     <= m22;
        win_row <= cen_row;
        win_col <= cen_col;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x3 frame: directed frames, scoreboard of
// expected windows, and hand-derived checks of selected windows.
module tb_window_gen_3x3;
  import pkg_edge::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int PIX_W = 8;
  localparam int WW    = 9 * PIX_W + 2 + 2 + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [PIX_W-1:0] in_pix;
  logic             in_ready;
  logic [PIX_W-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic             win_valid;
  logic [1:0]       win_row;
  logic [1:0]       win_col;
  logic             win_last;
  logic [1:0]       fsm_state;

  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_win[$];
  logic [WW-1:0] mon_g;
  logic [WW-1:0] hw;
  logic          acc_prev  = 1'b0;
  logic          flush_prev = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  window_gen_3x3 #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (PIX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pix    (in_pix),
    .in_ready  (in_ready),
    .p00       (p00),
    .p01       (p01),
    .p02       (p02),
    .p10       (p10),
    .p11       (p11),
    .p12       (p12),
    .p20       (p20),
    .p21       (p21),
    .p22       (p22),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .fsm_state (fsm_state)
  );

  // Clock and overall time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected window centred on (r, c) of a frame holding base+1..base+12.
  function automatic logic [WW-1:0] exp_win(input int base, input int r, input int c);
    logic [71:0] t;
    int rr, cc, v;
    t = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W) v = 0;
        else v = base + rr * IMG_W + cc + 1;
        t = {t[63:0], 8'(v)};
      end
    end
    return {t, 2'(r), 2'(c), (r == IMG_H - 1) && (c == IMG_W - 1)};
  endfunction

  // What gated the previous edge: an accepted beat or a flushing state.
  always @(posedge clk) begin
    acc_prev   <= in_valid && in_ready;
    flush_prev <= !in_ready;
  end

  // Scoreboard: every window pulse must be the next expected window.
  always @(negedge clk) begin
    if (win_valid) begin
      mon_g = {p00, p01, p02, p10, p11, p12, p20, p21, p22, win_row, win_col, win_last};
      got_win.push_back(mon_g);
      check("win_gate", acc_prev || flush_prev, 1'b1);
      if (exp_q.size() == 0) check("win_spurious", 1'b1, 1'b0);
      else check("win_seq", mon_g, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one pixel and return #1 after the edge that accepted it.
  task automatic send_pix(input int v);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_pix   = 8'(v);
    while (!in_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) check("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // One full frame, then measure the length of the in_ready-low flush gap.
  task automatic run_frame(input int base, input bit gaps);
    int low;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        exp_q.push_back(exp_win(base, r, c));
    for (int k = 0; k < IMG_W * IMG_H; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 3));
      send_pix(base + k + 1);
    end
    in_valid = 1'b0;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      low++;
      @(posedge clk);
      #1;
    end
    check("flush_len", low, IMG_W + 1);
  endtask

  task automatic check_reset();
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", win_valid, 1'b0);
    check("rst_last", win_last, 1'b0);
    check("rst_taps", {p00, p01, p02, p10, p11, p12, p20, p21, p22}, 72'd0);
    check("rst_pos", {win_row, win_col}, 4'd0);
    check("rst_state", fsm_state, FILL);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_pix   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    // Continuous frame 1..12 with hand-derived windows.
    got_win.delete();
    run_frame(0, 1'b0);
    idle(4);
    check("f1_count", got_win.size(), 12);
    check("f1_drain", exp_q.size(), 0);
    if (got_win.size() == 12) begin
      hw = got_win[0];
      check("c00_taps", hw[76:5], {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6});
      check("c00_pos", hw[4:0], {2'd0, 2'd0, 1'b0});
      hw = got_win[5];
      check("c11_taps", hw[76:5], {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      check("c11_pos", hw[4:0], {2'd1, 2'd1, 1'b0});
      hw = got_win[3];
      check("c03_taps", hw[76:5], {8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd7, 8'd8, 8'd0});
      check("c03_pos", hw[4:0], {2'd0, 2'd3, 1'b0});
      hw = got_win[11];
      check("c23_taps", hw[76:5], {8'd7, 8'd8, 8'd0, 8'd11, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0});
      check("c23_pos", hw[4:0], {2'd2, 2'd3, 1'b1});
    end

    // Same frame with in_valid dropped at random.
    got_win.delete();
    run_frame(0, 1'b1);
    idle(4);
    check("gap_count", got_win.size(), 12);
    check("gap_drain", exp_q.size(), 0);

    // Reset after 7 pixels: only centres (0,0) and (0,1) may appear.
    exp_q.push_back(exp_win(0, 0, 0));
    exp_q.push_back(exp_win(0, 0, 1));
    for (int k = 0; k < 7; k++) send_pix(k + 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();
    check("part_drain", exp_q.size(), 0);
    got_win.delete();
    run_frame(0, 1'b0);
    idle(4);
    check("post_rst_count", got_win.size(), 12);
    check("post_rst_drain", exp_q.size(), 0);

    // Back-to-back frames; the second frame must carry no first-frame data.
    got_win.delete();
    run_frame(0, 1'b0);
    run_frame(12, 1'b0);
    idle(4);
    check("b2b_count", got_win.size(), 24);
    check("b2b_drain", exp_q.size(), 0);
    if (got_win.size() == 24) begin
      hw = got_win[12];
      check("f2_c00_taps", hw[76:5], {8'd0, 8'd0, 8'd0, 8'd0, 8'd13, 8'd14, 8'd0, 8'd17, 8'd18});
      check("f2_c00_pos", hw[4:0], {2'd0, 2'd0, 1'b0});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
